// File: rtl/sys_pkg.sv
// Shared definitions for the sys_seq instruction sequencer: FSM state
// encodings and the default exception vector.
package sys_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_EXC    = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [7:0] EXC_VEC_DEF = 8'h80;

endpackage

// File: rtl/sys_seq_if.sv
// Control/status bundle between the sys_seq sequencer and its datapath.
// The sequencer takes the slave view; the datapath/bench takes master.
interface sys_seq_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16,
  parameter int N_EXC = 3
);

  logic                    SYS_load;
  logic [PC_W-1:0]         SYS_pc_val;
  logic                    SYS_step_mode;
  logic                    SYS_step;
  logic                    ctl_branch;
  logic                    alu_zero;
  logic                    ctl_jump;
  logic                    ctl_mem;
  logic                    ctl_regwr;
  logic signed [PC_W-1:0]  imm;
  logic [PC_W-3:0]         jtarget;
  logic [N_EXC-1:0]        exc_req;

  logic [PC_W-1:0]         PC_out;
  logic [PC_W-1:0]         EPC;
  logic [N_EXC-1:0]        cause;
  logic                    ir_load;
  logic                    mem_en;
  logic                    reg_we;
  logic [2:0]              state;
  logic                    exc_active;
  logic [CNT_W-1:0]        retired;

  modport master (
    output SYS_load, SYS_pc_val, SYS_step_mode, SYS_step,
           ctl_branch, alu_zero, ctl_jump, ctl_mem, ctl_regwr,
           imm, jtarget, exc_req,
    input  PC_out, EPC, cause, ir_load, mem_en, reg_we,
           state, exc_active, retired
  );

  modport slave (
    input  SYS_load, SYS_pc_val, SYS_step_mode, SYS_step,
           ctl_branch, alu_zero, ctl_jump, ctl_mem, ctl_regwr,
           imm, jtarget, exc_req,
    output PC_out, EPC, cause, ir_load, mem_en, reg_we,
           state, exc_active, retired
  );

endinterface

// File: rtl/sys_seq_pc_next.sv
// Next-PC selection for a retiring instruction: jump, taken branch or
// fall-through. Purely combinational; all arithmetic wraps at 2^PC_W.
module pc_next #(
  parameter int PC_W = 8
) (
  input  logic                   jump_i,
  input  logic                   branch_i,
  input  logic                   zero_i,
  input  logic [PC_W-1:0]        pc_i,
  input  logic signed [PC_W-1:0] imm_i,
  input  logic [PC_W-3:0]        jtarget_i,
  output logic [PC_W-1:0]        npc_o
);

  logic [PC_W-1:0]        pc4;
  logic signed [PC_W-1:0] boff;

  always_comb begin
    pc4  = pc_i + PC_W'(4);
    boff = imm_i <<< 2;
    // {pc4[top:top-1], jtarget, 00} truncated to PC_W leaves only jtarget,00
    if (jump_i) begin
      npc_o = {jtarget_i, 2'b00};
    end else if (branch_i && zero_i) begin
      npc_o = pc4 + $unsigned(boff);
    end else begin
      npc_o = pc4;
    end
  end

endmodule

// File: rtl/sys_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with
// precise exceptions, single-step halt and asynchronous PC load.
module sys_seq
  import sys_pkg::*;
#(
  parameter int              PC_W    = 8,
  parameter logic [PC_W-1:0] EXC_VEC = PC_W'(EXC_VEC_DEF),
  parameter int              CNT_W   = 16,
  parameter int              N_EXC   = 3
) (
  input logic      SYS_clk,
  input logic      SYS_reset,
  sys_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  epc_q, epc_d;
  logic [N_EXC-1:0] cause_q, cause_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             regwr_q, regwr_d;
  logic             step_q;
  logic [PC_W-1:0]  npc_q, npc_d, npc_w;
  logic [N_EXC-1:0] exc_pend_q, exc_pend_d;

  logic ld;
  logic exc_any;
  logic step_rise;

  function automatic logic [N_EXC-1:0] lowest_one(input logic [N_EXC-1:0] v);
    return v & (~v + N_EXC'(1));
  endfunction

  assign ld        = bus.SYS_load;
  assign exc_any   = |bus.exc_req;
  assign step_rise = bus.SYS_step & ~step_q;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .jump_i    (bus.ctl_jump),
    .branch_i  (bus.ctl_branch),
    .zero_i    (bus.alu_zero),
    .pc_i      (pc_q),
    .imm_i     (bus.imm),
    .jtarget_i (bus.jtarget),
    .npc_o     (npc_w)
  );

  // state register
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (exc_any)          state_d = S_EXC;
        else if (bus.ctl_mem) state_d = S_MEM;
        else                  state_d = S_WB;
      end
      S_MEM:    state_d = S_WB;
      S_WB:     state_d = bus.SYS_step_mode ? S_HALT : S_FETCH;
      S_EXC:    state_d = S_FETCH;
      S_HALT: begin
        if (step_rise || !bus.SYS_step_mode) state_d = S_FETCH;
      end
      default:  state_d = S_FETCH;
    endcase
    if (ld) state_d = S_FETCH;
  end

  // strobes: a load abandons the in-flight instruction for this cycle
  always_comb begin
    bus.ir_load    = 1'b0;
    bus.mem_en     = 1'b0;
    bus.reg_we     = 1'b0;
    bus.exc_active = SYS_reset && (state_q == S_EXC);
    if (SYS_reset && !ld) begin
      case (state_q)
        S_FETCH: bus.ir_load = 1'b1;
        S_MEM:   bus.mem_en  = 1'b1;
        S_WB:    bus.reg_we  = regwr_q;
        default: ;
      endcase
    end
  end

  // architectural state next values
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    ret_d      = ret_q;
    regwr_d    = regwr_q;
    npc_d      = npc_q;
    exc_pend_d = exc_pend_q;
    if (state_q == S_EXEC) begin
      regwr_d    = bus.ctl_regwr & ~exc_any;
      npc_d      = npc_w;
      exc_pend_d = lowest_one(bus.exc_req);
    end
    if (ld) begin
      pc_d = bus.SYS_pc_val;
    end else if (state_q == S_WB) begin
      pc_d  = npc_q;
      ret_d = ret_q + CNT_W'(1);
    end else if (state_q == S_EXC) begin
      pc_d    = EXC_VEC;
      epc_d   = pc_q;
      cause_d = exc_pend_q;
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      pc_q    <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      ret_q   <= '0;
      regwr_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      ret_q   <= ret_d;
      regwr_q <= regwr_d;
      step_q  <= bus.SYS_step;
    end
  end

  // EXEC-captured operands consumed in WB/EXC; always written before use
  always_ff @(posedge SYS_clk) begin
    npc_q      <= npc_d;
    exc_pend_q <= exc_pend_d;
  end

  assign bus.PC_out  = pc_q;
  assign bus.EPC     = epc_q;
  assign bus.cause   = cause_q;
  assign bus.retired = ret_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_sys_seq.sv
// Scoreboard bench for sys_seq: directed instructions queue their expected
// strobe events; a negedge monitor pops and compares each one.
module tb_sys_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sys_seq_if #(.PC_W(8), .CNT_W(16), .N_EXC(3)) bus ();

  sys_seq #(
    .PC_W    (8),
    .EXC_VEC (8'h80),
    .CNT_W   (16),
    .N_EXC   (3)
  ) dut (
    .SYS_clk   (clk),
    .SYS_reset (rst_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic [3:0]  strb;   // {ir_load, mem_en, reg_we, exc_active}
    logic [2:0]  st;
    logic [7:0]  pc;
    logic [7:0]  epc;
    logic [2:0]  cause;
    logic [15:0] ret;
  } ev_t;

  ev_t   exp_q[$];
  string nm_q[$];
  int    n_pass = 0;
  int    n_tot  = 0;
  bit    mon_en = 1'b0;

  logic [7:0]  m_pc;
  logic [7:0]  m_epc;
  logic [2:0]  m_cause;
  logic [15:0] m_ret;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic push(input string nm, input logic [3:0] s, input logic [2:0] st);
    ev_t e;
    e.strb  = s;
    e.st    = st;
    e.pc    = m_pc;
    e.epc   = m_epc;
    e.cause = m_cause;
    e.ret   = m_ret;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctl();
    bus.ctl_mem    = 1'b0;
    bus.ctl_regwr  = 1'b0;
    bus.ctl_branch = 1'b0;
    bus.alu_zero   = 1'b0;
    bus.ctl_jump   = 1'b0;
    bus.imm        = 8'h00;
    bus.jtarget    = 6'h00;
    bus.exc_req    = 3'b000;
  endtask

  // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH/HALT.
  task automatic instr(input string nm, input bit mem, input bit rw, input bit br,
                       input bit zr, input bit jp, input logic [7:0] imm_v,
                       input logic [5:0] jt, input logic [2:0] exc,
                       input logic [7:0] npc, input logic [2:0] ecause);
    push({nm, "_fetch"}, 4'b1000, 3'd0);
    if (exc != 3'b000) begin
      push({nm, "_exc"}, 4'b0001, 3'd5);
    end else begin
      if (mem) push({nm, "_mem"}, 4'b0100, 3'd3);
      if (rw)  push({nm, "_wb"},  4'b0010, 3'd4);
    end
    bus.ctl_mem    = mem;
    bus.ctl_regwr  = rw;
    bus.ctl_branch = br;
    bus.alu_zero   = zr;
    bus.ctl_jump   = jp;
    bus.imm        = imm_v;
    bus.jtarget    = jt;
    bus.exc_req    = exc;
    tick();
    chk({nm, "_decode"}, 32'(bus.state), 32'd1);
    tick();
    chk({nm, "_exec"}, 32'(bus.state), 32'd2);
    tick();
    clr_ctl();
    if (mem && exc == 3'b000) tick();
    tick();
    if (exc != 3'b000) begin
      m_epc   = m_pc;
      m_cause = ecause;
      m_pc    = 8'h80;
    end else begin
      m_pc  = npc;
      m_ret = m_ret + 16'd1;
    end
  endtask

  task automatic load_pc(input logic [7:0] v);
    bus.SYS_load   = 1'b1;
    bus.SYS_pc_val = v;
    tick();
    bus.SYS_load   = 1'b0;
    m_pc           = v;
  endtask

  // monitor: every strobe-bearing cycle must match the head of the queue
  initial forever begin
    ev_t   got;
    ev_t   e;
    string n;
    @(negedge clk);
    if (mon_en && rst_n && (bus.ir_load || bus.mem_en || bus.reg_we || bus.exc_active)) begin
      got = {bus.ir_load, bus.mem_en, bus.reg_we, bus.exc_active, bus.state,
             bus.PC_out, bus.EPC, bus.cause, bus.retired};
      n_tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: got %h expected none", got);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (got === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, got, e);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.SYS_load       = 1'b0;
    bus.SYS_pc_val     = 8'h00;
    bus.SYS_step_mode  = 1'b0;
    bus.SYS_step       = 1'b0;
    clr_ctl();
    m_pc = 8'h00; m_epc = 8'h00; m_cause = 3'b000; m_ret = 16'd0;

    #3;
    chk("rst_state",   32'(bus.state),   32'd0);
    chk("rst_pc",      32'(bus.PC_out),  32'h00);
    chk("rst_epc",     32'(bus.EPC),     32'h00);
    chk("rst_cause",   32'(bus.cause),   32'd0);
    chk("rst_retired", 32'(bus.retired), 32'd0);
    chk("rst_strobes", 32'({bus.ir_load, bus.mem_en, bus.reg_we, bus.exc_active}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    instr("alu0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 3'b000, 8'h04, 3'b000);
    load_pc(8'h08);
    instr("lw8",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 3'b000, 8'h0C, 3'b000);
    load_pc(8'h10);
    instr("beq",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFE, 6'h00, 3'b000, 8'h0C, 3'b000);
    instr("bnt",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, 6'h00, 3'b000, 8'h10, 3'b000);
    load_pc(8'hFC);
    instr("bwrap", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 6'h00, 3'b000, 8'h04, 3'b000);
    instr("jmp",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 6'h15, 3'b000, 8'h54, 3'b000);
    load_pc(8'h20);
    instr("exc110", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 3'b110, 8'h00, 3'b010);
    instr("exc101", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 3'b101, 8'h00, 3'b001);

    bus.SYS_step_mode = 1'b1;
    instr("step1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 3'b000, 8'h84, 3'b000);
    for (int i = 0; i < 10; i++) begin
      chk("halt_hold", 32'(bus.state), 32'd6);
      tick();
    end
    chk("halt_hold_end", 32'(bus.state), 32'd6);
    bus.SYS_step = 1'b1;
    tick();
    chk("step_release", 32'(bus.state), 32'd0);
    instr("step2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 3'b000, 8'h88, 3'b000);
    for (int i = 0; i < 5; i++) begin
      chk("halt_step_held", 32'(bus.state), 32'd6);
      tick();
    end
    bus.SYS_step_mode = 1'b0;
    tick();
    chk("mode_clear_release", 32'(bus.state), 32'd0);
    bus.SYS_step = 1'b0;

    push("ldmem_fetch", 4'b1000, 3'd0);
    bus.ctl_mem   = 1'b1;
    bus.ctl_regwr = 1'b1;
    tick();
    tick();
    tick();
    chk("ldmem_in_mem", 32'(bus.state), 32'd3);
    clr_ctl();
    bus.SYS_load   = 1'b1;
    bus.SYS_pc_val = 8'h40;
    tick();
    bus.SYS_load   = 1'b0;
    m_pc           = 8'h40;
    chk("ldmem_state", 32'(bus.state),  32'd0);
    chk("ldmem_pc",    32'(bus.PC_out), 32'h40);
    instr("after_ld", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 3'b000, 8'h44, 3'b000);

    push("arst_fetch", 4'b1000, 3'd0);
    bus.ctl_regwr = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state",   32'(bus.state),   32'd0);
    chk("arst_pc",      32'(bus.PC_out),  32'h00);
    chk("arst_epc",     32'(bus.EPC),     32'h00);
    chk("arst_cause",   32'(bus.cause),   32'd0);
    chk("arst_retired", 32'(bus.retired), 32'd0);
    chk("arst_strobes", 32'({bus.ir_load, bus.mem_en, bus.reg_we, bus.exc_active}), 32'd0);
    clr_ctl();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = 8'h00; m_epc = 8'h00; m_cause = 3'b000; m_ret = 16'd0;

    instr("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 3'b000, 8'h04, 3'b000);
    mon_en = 1'b0;
    chk("final_pc",      32'(bus.PC_out),  32'h04);
    chk("final_retired", 32'(bus.retired), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sys_seq.md
SYS_SEQ -- requirements
Module: sys_seq

Interface
REQ-001 Parameter PC_W, default 8, meaning PC/EPC/address width in bits (≥4).
REQ-002 Parameter EXC_VEC, default 8'h80 (PC_W bits), meaning exception handler address.
REQ-003 Parameter CNT_W, default 16, meaning retired-instruction counter width.
REQ-004 Parameter N_EXC, default 3, meaning number of exception request lines.
REQ-005 SYS_clk  in  1  sole clock, all state on rising edge.
REQ-006 SYS_reset  in  1  asynchronous, active-low reset.
REQ-007 SYS_load  in  1  synchronous PC load request.
REQ-008 SYS_pc_val  in  PC_W  value loaded on SYS_load.
REQ-009 SYS_step_mode  in  1  1 = halt after each retired instruction.
REQ-010 SYS_step  in  1  level input; its rising edge releases HALT.
REQ-011 ctl_branch, alu_zero, ctl_jump, ctl_mem, ctl_regwr  in  1 each  decoded controls and ALU zero flag, valid in EXEC.
REQ-012 imm  in  PC_W  signed word offset; jtarget  in  PC_W-2  jump word index.
REQ-013 exc_req  in  N_EXC  exception requests, sampled in EXEC only.
REQ-014 PC_out  out  PC_W; EPC  out  PC_W; cause  out  N_EXC  one-hot latched cause.
REQ-015 ir_load, mem_en, reg_we  out  1 each  one-cycle strobes to datapath.
REQ-016 state  out  3  current FSM encoding; exc_active  out  1; retired  out  CNT_W.

Function
REQ-017 FSM states SHALL be FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), EXC(5), HALT(6).
REQ-018 FETCH->DECODE->EXEC unconditionally, one cycle each; ir_load SHALL be 1 only in FETCH.
REQ-019 EXEC: any exc_req bit set -> EXC; else ctl_mem -> MEM; else -> WB.
REQ-020 MEM: mem_en SHALL be 1 for exactly this cycle; MEM->WB.
REQ-021 WB: reg_we = ctl_regwr (registered in EXEC, masked 0 if excepted); PC updated; retired += 1 (wraps at 2^CNT_W); next = HALT if SYS_step_mode else FETCH.
REQ-022 PC update in WB: jump -> {pc4[PC_W-1:PC_W-2], jtarget, 2'b00} truncated to PC_W; else branch & zero -> pc4 + (imm<<2); else pc4; pc4 = PC_out+4; all arithmetic modulo 2^PC_W.
REQ-023 EXC: EPC <= PC_out of faulting instruction; cause <= lowest-index set exc_req bit only; PC_out <= EXEC_VEC; no reg_we, no mem_en, retired unchanged; exc_active = 1 in this cycle; next FETCH.
REQ-024 HALT: leave on first rising edge of SYS_step (edge detector registered); SYS_step high on HALT entry SHALL NOT release; clearing SYS_step_mode in HALT SHALL release next cycle.
REQ-025 SYS_load=1 in any state: PC_out <= SYS_pc_val, state <= FETCH, in-flight instruction abandoned (no strobes that cycle); EPC/cause/retired kept; overrides EXC and WB PC update.
REQ-026 Strobes SHALL be combinational decodes of registered state only; never asserted in HALT, EXC.

Reset
REQ-027 SYS_reset low: PC_out=0, EPC=0, cause=0, retired=0, state=FETCH, step edge register=0, all strobes 0; effective immediately, mid-instruction included.
REQ-028 First FETCH SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-029 State encodings and EXC_VEC default SHALL live in shared package sys_pkg.
REQ-030 PC next-address logic SHALL be sub-module pc_next (pure combinational, PC_W parametrised).

Verification
REQ-031 Reset, non-mem ALU instr, step_mode=0: states 0,1,2,4,0; PC 0->4; retired=1; reg_we one cycle in WB.
REQ-032 Load instr (ctl_mem=1) at PC 8: mem_en exactly one cycle in state 3; PC 12 after WB.
REQ-033 Branch at PC 0x10, zero=1, imm=-2: PC becomes 0x0C; with PC_W=8, PC 0xFC, imm=1 -> 0x04 (wrap).
REQ-034 exc_req=3'b110 in EXEC at PC 0x20: EPC=0x20, cause=3'b010, PC=0x80, reg_we never set, retired unchanged.
REQ-035 step_mode=1: after WB state=6 holds 10 cycles; SYS_step rise -> FETCH next cycle; held-high step gives no second release.
REQ-036 SYS_load with SYS_pc_val=0x40 during MEM: no WB strobe, PC=0x40, state=FETCH; async reset during EXEC clears all outputs without a clock edge.
